aud_sync_fifo: RTL
==================

// Module: aud_sync_fifo
// PURPOSE
//   Single-clock, parametrised FIFO for the AUD capture/transmit path.
//   Buffers DATA_WIDTH-bit words between the AUD core and host-side logic.
//   First-word-fall-through read, level/threshold flags, sticky overflow and
//   underflow error flags, and a synchronous flush.
// PARAMETERS
//   DATA_WIDTH     32           word width in bits (>=1)
//   ADDRESS_WIDTH  4            log2 of depth (>=1)
//   FIFO_DEPTH     1<<ADDRESS_WIDTH  fixed power of two; not overridden
//   AFULL_LEVEL    FIFO_DEPTH-2 afull_o asserts when count_o >= this value
//   AEMPTY_LEVEL   2            aempty_o asserts when count_o <= this value
// PORTS
//   clk        in   1               system clock, all logic on rising edge
//   rst        in   1               synchronous reset, active-high
//   flush_i    in   1               discard contents (synchronous)
//   clr_err_i  in   1               clear ovf_o/udf_o
//   dat_i      in   DATA_WIDTH      write data
//   we_i       in   1               write request, one word per cycle
//   re_i       in   1               read/pop request, one word per cycle
//   dat_o      out  DATA_WIDTH      head-of-FIFO word (FWFT)
//   valid_o    out  1               dat_o holds a valid word (== !empty_o)
//   empty_o    out  1               count_o == 0
//   full_o     out  1               count_o == FIFO_DEPTH
//   aempty_o   out  1               count_o <= AEMPTY_LEVEL
//   afull_o    out  1               count_o >= AFULL_LEVEL
//   count_o    out  ADDRESS_WIDTH+1 words stored, 0..FIFO_DEPTH
//   ovf_o      out  1               sticky: write rejected because full
//   udf_o      out  1               sticky: read rejected because empty
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): rptr=wptr=0, count_o=0, ovf_o=udf_o=0;
//     so empty_o=1, aempty_o=1, valid_o=0, full_o=0, afull_o=0. Memory not
//     reset; dat_o is don't-care while empty_o=1. rst overrides all inputs.
//   - Read accepted iff re_i && count_o!=0: rptr+1, next word appears on
//     dat_o in the following cycle. Head word is visible with no read latency.
//   - Write accepted iff we_i && (count_o!=FIFO_DEPTH || read accepted same
//     cycle): mem[wptr]<=dat_i, wptr+1.
//   - Write to empty FIFO: dat_o/valid_o valid on the cycle after the edge
//     (1-cycle write-to-read latency). No same-cycle bypass.
//   - count_o next = count_o + wr_acc - rd_acc. Simultaneous accepted read
//     and write leave count_o unchanged, including at full.
//   - we_i&&re_i when empty: write accepted, read rejected, udf_o set.
//   - Pointers are ADDRESS_WIDTH bits and wrap modulo FIFO_DEPTH naturally.
//   - All flags decode the registered count_o only; no input-to-output
//     combinational path except none (dat_o = mem[rptr] from registers).
//   - ovf_o set when we_i && write not accepted; udf_o set when re_i &&
//     count_o==0. Both hold until clr_err_i or rst; set wins over clr_err_i
//     in the same cycle.
//   - flush_i: rptr=wptr=0, count_o=0 next cycle; we_i/re_i ignored that
//     cycle (no ovf/udf set); sticky flags are NOT cleared by flush_i.
//   - Thresholds are static parameters; AEMPTY_LEVEL < AFULL_LEVEL required.
// TESTING
//   1 rst, write 0xA0..0xAF (16 words) -> full_o=1, afull_o=1 from count 14,
//     count_o=16; read 16 -> dat_o sequence 0xA0..0xAF, empty_o=1, no errors.
//   2 At full, we_i=1 with 0xDEAD, re_i=0 -> ovf_o=1, count_o stays 16, 0xDEAD
//     never read; clr_err_i pulse -> ovf_o=0 next cycle.
//   3 At full, we_i=re_i=1 for 20 cycles -> count_o stays 16, output order
//     preserved across pointer wrap, ovf_o stays 0.
//   4 Empty, we_i=re_i=1 with 0x55 -> udf_o=1, count_o=1, dat_o=0x55 next
//     cycle, valid_o=1.
//   5 count_o=5, flush_i=1 with we_i=1 -> count_o=0, empty_o=1, write lost;
//     pre-set udf_o remains 1.
//   6 Mid-stream (count_o=9) assert rst with we_i=re_i=1 -> next cycle all
//     outputs at reset values; subsequent write 0x11 reads back as 0x11.

Source files
------------

// File: rtl/aud_sync_fifo_if.sv
// rtl/aud_sync_fifo_if.sv - handshake/status bundle between the AUD FIFO and its user
//
// Purpose: groups every non-clock/reset signal of aud_sync_fifo.
//   master modport : the side that writes/reads the FIFO (drives *_i)
//   slave modport  : the FIFO itself (drives *_o)
// Signals:
//   flush_i, clr_err_i, dat_i, we_i, re_i           control/data into the FIFO
//   dat_o, valid_o, empty_o, full_o, aempty_o,
//   afull_o, count_o, ovf_o, udf_o                  head word and status out
interface aud_sync_fifo_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
);
  logic                   flush_i;
  logic                   clr_err_i;
  logic [DATA_WIDTH-1:0]  dat_i;
  logic                   we_i;
  logic                   re_i;
  logic [DATA_WIDTH-1:0]  dat_o;
  logic                   valid_o;
  logic                   empty_o;
  logic                   full_o;
  logic                   aempty_o;
  logic                   afull_o;
  logic [ADDRESS_WIDTH:0] count_o;
  logic                   ovf_o;
  logic                   udf_o;

  modport master (
    output flush_i, clr_err_i, dat_i, we_i, re_i,
    input  dat_o, valid_o, empty_o, full_o, aempty_o, afull_o, count_o, ovf_o, udf_o
  );

  modport slave (
    input  flush_i, clr_err_i, dat_i, we_i, re_i,
    output dat_o, valid_o, empty_o, full_o, aempty_o, afull_o, count_o, ovf_o, udf_o
  );
endinterface

// File: rtl/aud_sync_fifo.sv
// rtl/aud_sync_fifo.sv - single-clock first-word-fall-through FIFO for the AUD path
//
// Purpose: buffers DATA_WIDTH-bit words between the AUD core and host logic,
//   with level/threshold flags, sticky overflow/underflow flags and flush.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, overrides every other input
//   bus  : aud_sync_fifo_if.slave (write/read/flush/clear in, head word and
//          status flags out)
module aud_sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 2,
  parameter int AEMPTY_LEVEL  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  aud_sync_fifo_if.slave        bus
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LP_DEPTH  = (ADDRESS_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] LP_AFULL  = (ADDRESS_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] LP_AEMPTY = (ADDRESS_WIDTH+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_rptr;
  logic [ADDRESS_WIDTH-1:0] r_wptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_ovf;
  logic                     r_udf;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;
  logic w_udf_set;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);

  // Flush swallows the cycle's read/write requests entirely, including their
  // error side effects; reset likewise blocks any memory write.
  assign w_rd_acc  = !rst && !bus.flush_i && bus.re_i && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr_acc  = !rst && !bus.flush_i && bus.we_i && (!w_full || w_rd_acc);
  assign w_ovf_set = !bus.flush_i && bus.we_i && !w_wr_acc;
  assign w_udf_set = !bus.flush_i && bus.re_i && w_empty;

  // Storage is deliberately not reset; dat_o is meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= bus.dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ADDRESS_WIDTH'(1);
      end
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ADDRESS_WIDTH'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDRESS_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDRESS_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle beats clr_err_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_err_i) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (bus.clr_err_i) begin
        r_udf <= 1'b0;
      end
    end
  end

  // All outputs derive from registered state only.
  assign bus.dat_o    = r_mem[r_rptr];
  assign bus.valid_o  = !w_empty;
  assign bus.empty_o  = w_empty;
  assign bus.full_o   = w_full;
  assign bus.aempty_o = (r_count <= LP_AEMPTY);
  assign bus.afull_o  = (r_count >= LP_AFULL);
  assign bus.count_o  = r_count;
  assign bus.ovf_o    = r_ovf;
  assign bus.udf_o    = r_udf;

endmodule
